pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
Parametrised program counter and instruction-fetch register for the next-generation CPU datapath, replacing the fixed 8-bit PC, PC+1 adder and PC mux. It drives the instruction memory address and latches the returned instruction into a fetch register (IF/ID boundary) for a two-stage pipeline. It adds reset vector, stall, branch redirect with wrong-path squash, HALT detection/resume and a saturating fetch counter.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 16, instruction width
OPC_W, 4, opcode field width, taken from instr[INSTR_W-1 -: OPC_W]
HALT_OPC, 4'hF, opcode value that halts fetch
RESET_VEC, 0, PC value after reset
COUNT_W, 16, fetch counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  PC_W  instruction memory address, combinational = pc
imem_rdata  input  INSTR_W  instruction memory read data, combinational from imem_addr
stall  input  1  hold PC and fetch register this cycle
branch_taken  input  1  redirect request from execute stage
branch_target  input  PC_W  redirect address
resume  input  1  leave HALTED state
if_valid  output  1  fetch register holds a valid instruction
if_instr  output  INSTR_W  fetched instruction
if_pc  output  PC_W  address of if_instr
if_pc_plus1  output  PC_W  if_pc+1 mod 2^PC_W (link/branch base)
halted  output  1  high while in HALTED state
fetch_count  output  COUNT_W  number of valid instructions latched

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, state=RUN, if_valid=0, if_instr=0, if_pc=0, fetch_count=0; halted=0. All outputs take reset values immediately, independent of clk.
- States: RUN, HALTED. halted = (state==HALTED).
- Priority each edge: branch_taken > stall > normal fetch / HALT detect; resume only acts in HALTED.
- RUN, branch_taken=1: pc<=branch_target; if_valid<=0 (wrong-path squash, one bubble); if_instr/if_pc hold; stall ignored.
- RUN, stall=1, no branch: pc, if_* and fetch_count hold.
- RUN, normal fetch: if_instr<=imem_rdata; if_pc<=pc; if_valid<=1; fetch_count+=1.
  - opcode(imem_rdata)!=HALT_OPC: pc<=pc+1, wrap 2^PC_W-1 -> 0.
  - opcode==HALT_OPC: HALT latched as valid once; pc holds (points at HALT); state<=HALTED.
- HALTED: if_valid<=0 every cycle, pc holds, no counting.
  - branch_taken=1: pc<=branch_target; state<=RUN (older in-flight branch wins over halt).
  - else resume=1: pc<=pc+1; state<=RUN; first post-halt fetch on following edge.
  - stall ignored in HALTED.
- fetch_count saturates at 2^COUNT_W-1; never wraps.
- Latency: instruction at address A appears on if_instr one edge after imem_addr==A. Branch: target instruction valid two edges after branch edge.
- if_pc_plus1 combinational from if_pc, same wrap rule.
- Reset mid-operation (any state, stall/branch asserted): immediate return to reset values; no pending redirect survives.

Test Plan:
- Reset then free-run, PC_W=8, RESET_VEC=8'h10, memory holds opcode 0 -> imem_addr 10,11,12...; if_pc lags by one cycle; if_valid=1 from 2nd edge; fetch_count increments by 1 per edge.
- Wrap: RESET_VEC=8'hFE -> addresses FE,FF,00,01; if_pc_plus1=00 when if_pc=FF.
- Stall 3 cycles at pc=8'h05 -> imem_addr stays 05, if_instr/if_pc/fetch_count frozen; resume on stall=0 with 05 latched next edge.
- Branch at pc=8'h20 to 8'h40 with stall=1 simultaneously -> next edge pc=40, if_valid=0; following edge if_pc=40, if_valid=1; instruction at 20 never counted.
- HALT (16'hF000) at 8'h30 -> latched once valid, halted=1, imem_addr stays 30, if_valid=0 thereafter; resume pulse -> pc=31, halted=0, 31 fetched next edge; repeat with branch_taken to 8'h50 in HALTED -> pc=50, RUN.
- rst_n low mid-branch and in HALTED -> outputs reset asynchronously before next edge; COUNT_W=2 run 5 fetches -> fetch_count sticks at 3.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
// Program counter and IF/ID fetch register for a two-stage pipeline.
// The PC drives the instruction memory address directly. The returned
// instruction is latched into the fetch register together with its address.
// The stage also provides:
//   - a reset vector
//   - stall
//   - branch redirect with a one-bubble wrong-path squash
//   - HALT-opcode detection with resume
//   - a saturating count of latched instructions
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   imem_addr     instruction memory address (= pc)
//   imem_rdata    instruction memory read data (combinational from imem_addr)
//   stall         hold pc and fetch register (RUN only)
//   branch_taken  redirect request from execute
//   branch_target redirect address
//   resume        leave HALTED
//   if_valid      fetch register holds a valid instruction
//   if_instr      fetched instruction
//   if_pc         address of if_instr
//   if_pc_plus1   if_pc + 1, wrapping
//   halted        high while halted
//   fetch_count   saturating count of valid instructions latched
module pc_fetch_stage #(
  parameter int                PC_W      = 8,
  parameter int                INSTR_W   = 16,
  parameter int                OPC_W     = 4,
  parameter logic [OPC_W-1:0]  HALT_OPC  = 4'hF,
  parameter logic [PC_W-1:0]   RESET_VEC = '0,
  parameter int                COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               resume,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus1,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

  logic [0:0]         state;
  logic [PC_W-1:0]    pc_p0;
  logic               vld_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [COUNT_W-1:0] cnt_p1;
  logic [OPC_W-1:0]   opc;

  assign opc = imem_rdata[INSTR_W-1 -: OPC_W];

  // Stage 0 -> 1: PC update and IF/ID fetch register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc_p0    <= RESET_VEC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      cnt_p1   <= '0;
    end else if (state == HALTED) begin
      vld_p1 <= 1'b0;
      // A branch issued before the HALT was fetched still wins over the halt.
      if (branch_taken) begin
        pc_p0 <= branch_target;
        state <= RUN;
      end else if (resume) begin
        pc_p0 <= pc_inc(pc_p0);
        state <= RUN;
      end
    end else if (branch_taken) begin
      // The instruction currently on imem_rdata is wrong-path: drop it.
      pc_p0  <= branch_target;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      instr_p1 <= imem_rdata;
      pc_p1    <= pc_p0;
      vld_p1   <= 1'b1;
      cnt_p1   <= sat_inc(cnt_p1);
      // On HALT the pc keeps pointing at the HALT so resume continues after it.
      if (opc == HALT_OPC) state <= HALTED;
      else                 pc_p0 <= pc_inc(pc_p0);
    end
  end

  assign imem_addr   = pc_p0;
  assign if_valid    = vld_p1;
  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign if_pc_plus1 = pc_inc(pc_p1);
  assign halted      = (state == HALTED);
  assign fetch_count = cnt_p1;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage.
// Two instances share one instruction memory:
//   u0: RESET_VEC=8'h10, COUNT_W=16
//   u1: RESET_VEC=8'hFE, COUNT_W=2  (address wrap and counter saturation)
// An integer-level model of the fetch rules predicts every output.
// The model is compared on each falling edge.
// Directed steps also pin literal values.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i  [2];
  logic        br_i     [2];
  logic        res_i    [2];
  logic [7:0]  tgt_i    [2];
  logic [15:0] mem      [256];

  logic [7:0]  addr0, addr1, ifpc0, ifpc1, p1_0, p1_1;
  logic [15:0] rd0, rd1, ins0, ins1, cnt0;
  logic [1:0]  cnt1;
  logic        v0, v1, h0, h1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  assign rd0 = mem[addr0];
  assign rd1 = mem[addr1];

  always #5 clk = ~clk;

  pc_fetch_stage #(.PC_W(8), .INSTR_W(16), .OPC_W(4), .HALT_OPC(4'hF),
                   .RESET_VEC(8'h10), .COUNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr0), .imem_rdata(rd0),
    .stall(stall_i[0]), .branch_taken(br_i[0]), .branch_target(tgt_i[0]),
    .resume(res_i[0]), .if_valid(v0), .if_instr(ins0), .if_pc(ifpc0),
    .if_pc_plus1(p1_0), .halted(h0), .fetch_count(cnt0));

  pc_fetch_stage #(.PC_W(8), .INSTR_W(16), .OPC_W(4), .HALT_OPC(4'hF),
                   .RESET_VEC(8'hFE), .COUNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr1), .imem_rdata(rd1),
    .stall(stall_i[1]), .branch_taken(br_i[1]), .branch_target(tgt_i[1]),
    .resume(res_i[1]), .if_valid(v1), .if_instr(ins1), .if_pc(ifpc1),
    .if_pc_plus1(p1_1), .halted(h1), .fetch_count(cnt1));

  // ---------------- behavioural model ----------------
  int rv   [2] = '{16, 254};
  int cmax [2] = '{65535, 3};
  int m_pc [2], m_h [2], m_v [2], m_ins [2], m_ipc [2], m_cnt [2];

  task automatic model_step(input int k);
    int d;
    if (m_h[k] != 0) begin
      m_v[k] = 0;
      if (br_i[k]) begin
        m_pc[k] = int'(tgt_i[k]);
        m_h[k] = 0;
      end else if (res_i[k]) begin
        m_pc[k] = (m_pc[k] + 1) % 256;
        m_h[k] = 0;
      end
    end else if (br_i[k]) begin
      m_pc[k] = int'(tgt_i[k]);
      m_v[k] = 0;
    end else if (!stall_i[k]) begin
      d = int'(mem[m_pc[k]]);
      m_ins[k] = d;
      m_ipc[k] = m_pc[k];
      m_v[k] = 1;
      if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      if ((d >> 12) == 15) m_h[k] = 1;
      else m_pc[k] = (m_pc[k] + 1) % 256;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = rv[k]; m_h[k] = 0; m_v[k] = 0;
        m_ins[k] = 0; m_ipc[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input int a, input int v, input int ins,
                          input int ipc, input int p1, input int h, input int c);
    string s;
    s = $sformatf("u%0d", k);
    chk({s, ".imem_addr"}, a, m_pc[k]);
    chk({s, ".if_valid"}, v, m_v[k]);
    chk({s, ".if_instr"}, ins, m_ins[k]);
    chk({s, ".if_pc"}, ipc, m_ipc[k]);
    chk({s, ".if_pc_plus1"}, p1, (m_ipc[k] + 1) % 256);
    chk({s, ".halted"}, h, m_h[k]);
    chk({s, ".fetch_count"}, c, m_cnt[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, int'(addr0), int'(v0), int'(ins0), int'(ifpc0), int'(p1_0), int'(h0), int'(cnt0));
      cmp_inst(1, int'(addr1), int'(v1), int'(ins1), int'(ifpc1), int'(p1_1), int'(h1), int'(cnt1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h30] = 16'hF000;
    for (int k = 0; k < 2; k++) begin
      stall_i[k] = 1'b0; br_i[k] = 1'b0; res_i[k] = 1'b0; tgt_i[k] = 8'h00;
    end
    rst_n = 1'b0;
    #12;
    chk("rst addr0", int'(addr0), 'h10);
    chk("rst addr1", int'(addr1), 'hFE);
    chk("rst valid0", int'(v0), 0);
    chk("rst count0", int'(cnt0), 0);
    chk("rst halted0", int'(h0), 0);
    step(1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // free run and wrap
    step(1);
    chk("run addr0", int'(addr0), 'h11);
    chk("run ifpc0", int'(ifpc0), 'h10);
    chk("run valid0", int'(v0), 1);
    chk("run cnt0", int'(cnt0), 1);
    chk("wrap ifpc1", int'(ifpc1), 'hFE);
    step(1);
    chk("wrap addr1", int'(addr1), 'h00);
    chk("wrap ifpc1b", int'(ifpc1), 'hFF);
    chk("wrap plus1", int'(p1_1), 'h00);
    step(3);
    chk("run cnt0b", int'(cnt0), 5);
    chk("sat cnt1", int'(cnt1), 3);

    // stall at 05
    br_i[0] = 1'b1; tgt_i[0] = 8'h05;
    step(1);
    br_i[0] = 1'b0;
    chk("br addr05", int'(addr0), 'h05);
    chk("br squash", int'(v0), 0);
    stall_i[0] = 1'b1;
    step(3);
    chk("stall addr", int'(addr0), 'h05);
    chk("stall cnt", int'(cnt0), 5);
    stall_i[0] = 1'b0;
    step(1);
    chk("unstall ifpc", int'(ifpc0), 'h05);
    chk("unstall instr", int'(ins0), 'h0005);
    chk("unstall cnt", int'(cnt0), 6);

    // branch with simultaneous stall
    br_i[0] = 1'b1; tgt_i[0] = 8'h20;
    step(1);
    stall_i[0] = 1'b1; tgt_i[0] = 8'h40;
    step(1);
    br_i[0] = 1'b0; stall_i[0] = 1'b0;
    chk("brst addr", int'(addr0), 'h40);
    chk("brst valid", int'(v0), 0);
    chk("brst cnt", int'(cnt0), 6);
    step(1);
    chk("brtgt ifpc", int'(ifpc0), 'h40);
    chk("brtgt valid", int'(v0), 1);
    chk("brtgt cnt", int'(cnt0), 7);

    // HALT and resume
    br_i[0] = 1'b1; tgt_i[0] = 8'h30;
    step(1);
    br_i[0] = 1'b0;
    step(1);
    chk("halt instr", int'(ins0), 'hF000);
    chk("halt valid", int'(v0), 1);
    chk("halt flag", int'(h0), 1);
    chk("halt cnt", int'(cnt0), 8);
    step(2);
    chk("halted addr", int'(addr0), 'h30);
    chk("halted valid", int'(v0), 0);
    chk("halted cnt", int'(cnt0), 8);
    res_i[0] = 1'b1;
    step(1);
    res_i[0] = 1'b0;
    chk("resume addr", int'(addr0), 'h31);
    chk("resume flag", int'(h0), 0);
    step(1);
    chk("resume ifpc", int'(ifpc0), 'h31);
    chk("resume cnt", int'(cnt0), 9);

    // branch out of HALTED
    br_i[0] = 1'b1; tgt_i[0] = 8'h30;
    step(1);
    br_i[0] = 1'b0;
    step(1);
    chk("halt2 flag", int'(h0), 1);
    br_i[0] = 1'b1; tgt_i[0] = 8'h50;
    step(1);
    br_i[0] = 1'b0;
    chk("hbr addr", int'(addr0), 'h50);
    chk("hbr flag", int'(h0), 0);

    // async reset while a branch is requested
    br_i[0] = 1'b1; tgt_i[0] = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    chk("arst addr0", int'(addr0), 'h10);
    chk("arst cnt0", int'(cnt0), 0);
    chk("arst addr1", int'(addr1), 'hFE);
    step(1);
    br_i[0] = 1'b0;
    rst_n = 1'b1;
    chk("arst nobr", int'(addr0), 'h10);

    // async reset while halted
    br_i[0] = 1'b1; tgt_i[0] = 8'h30;
    step(1);
    br_i[0] = 1'b0;
    step(1);
    chk("hrst pre", int'(h0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("hrst flag", int'(h0), 0);
    chk("hrst addr", int'(addr0), 'h10);
    chk("hrst valid", int'(v0), 0);
    step(1);
    rst_n = 1'b1;

    // randomized phase
    for (int i = 0; i < 12; i++) mem[$urandom_range(0, 255)] = 16'hF000 | 16'($urandom_range(0, 255));
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        br_i[k]    = ($urandom_range(0, 7) == 0);
        stall_i[k] = ($urandom_range(0, 3) == 0);
        res_i[k]   = ($urandom_range(0, 3) == 0);
        tgt_i[k]   = 8'($urandom_range(0, 255));
      end
      rst_n = ($urandom_range(0, 63) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(1);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
